bidder_port_agent: RTL and testbench
====================================

// Module: bidder_port_agent
// PURPOSE
//  Bidder-side endpoint of one BIDS22 bidder port (x_/y_/z_ signals); one instance per bidder.
//  Accepts bid/retract commands from an upstream client and drives them to the controller.
//  Waits for ack, captures err/balance and retries on ack timeout.
//  Returns one response per command and latches round wins.
// PARAMETERS
//  AMT_W        16  bid amount width (matches controller bidAmt)
//  BAL_W        32  balance width (matches controller balance)
//  ACK_TIMEOUT  15  cycles in WAIT_ACK without ack before retry/timeout (1..255)
//  MAX_RETRY    3   re-issues after a timeout before giving up (0..7)
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      reset, synchronous, active-low
//  cmd_valid    in   1      client command valid
//  cmd_ready    out  1      agent can accept command (high only in IDLE)
//  cmd_retract  in   1      1=retract, 0=bid
//  cmd_amt      in   AMT_W  bid amount (ignored for retract)
//  bid          out  1      to controller: bid request pulse
//  retract      out  1      to controller: retract request pulse
//  bidAmt       out  AMT_W  to controller: amount, stable ISSUE..WAIT_ACK
//  ack          in   1      from controller: request acknowledged
//  err          in   2      from controller: 00 ok, 01 round inactive, 10 insufficient funds, 11 invalid
//  win          in   1      from controller: this bidder won
//  balance      in   BAL_W  from controller: current balance
//  roundOver    in   1      from controller: round ended
//  rsp_valid    out  1      one-cycle response pulse, no backpressure
//  rsp_err      out  3      0-3 = controller err; 4 = timeout; 5 = local funds (macro only)
//  rsp_balance  out  BAL_W  balance captured with ack (held until next ack)
//  won          out  1      sticky win flag for last completed round
//  busy         out  1      ~cmd_ready
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; bid=retract=0; bidAmt=0; rsp_valid=0; rsp_err=0;
//   rsp_balance=0; won=0; retry and timer counters=0. Reset mid-transaction aborts it, no rsp.
//  FSM: IDLE -> ISSUE -> WAIT_ACK -> RESP -> IDLE.
//  IDLE: cmd_valid&cmd_ready at cycle T latches cmd_retract and cmd_amt; clears won and retry count.
//  ISSUE (T+1):
//   - Exactly one of bid/retract is high for exactly one cycle; bidAmt=latched amt (0 for retract).
//   - Timer cleared. Next state WAIT_ACK.
//  WAIT_ACK:
//   - bid/retract low. ack is sampled in this state only; ack during ISSUE is ignored.
//   - On ack: capture err into rsp_err[1:0] (rsp_err[2]=0) and balance into rsp_balance;
//     go to RESP.
//   - No ack: timer++ each cycle. On timer==ACK_TIMEOUT-1 without ack:
//     - retry<MAX_RETRY: retry++, back to ISSUE (re-pulse, same amount);
//     - else: rsp_err=4, rsp_balance unchanged, go to RESP.
//   - ack and timeout in the same cycle: ack wins.
//  RESP: rsp_valid=1 for one cycle, then IDLE. Best-case latency: accept T, bid T+1, ack T+2,
//   rsp_valid T+3; cmd_ready high again at T+4.
//  bidAmt held from ISSUE until next accepted command (not cleared in IDLE).
//  won: set when win&roundOver are high in the same cycle (any state); cleared only on command accept.
//   Set and clear in the same cycle: clear wins.
//  roundOver does not abort WAIT_ACK; the controller is expected to ack with err=01.
//  rsp_err/rsp_balance hold their values outside RESP.
//  cmd_amt=0 is passed through unchanged; the controller decides validity.
// CONFIGURATION
//  BID_LOCAL_FUNDS_CHECK_EN defined:
//   - A bid command whose cmd_amt > rsp_balance skips ISSUE/WAIT_ACK: IDLE -> RESP,
//     rsp_err=5, no bid pulse.
//   - The check is bypassed until the first ack after reset; retracts are never checked.
//  BID_LOCAL_FUNDS_CHECK_EN undefined: every command is issued to the controller;
//   rsp_err is never 5.
// TESTING
//  1 Bid 100, ack+err=00+balance=900 two cycles after accept -> bid pulse 1 cycle at T+1, bidAmt=100,
//    rsp_valid at T+3, rsp_err=0, rsp_balance=900.
//  2 Retract, ack with err=11 -> retract pulse only, bidAmt=0, rsp_err=3.
//  3 Bid 50, no ack, ACK_TIMEOUT=15, MAX_RETRY=3 -> 4 bid pulses spaced 16 cycles apart,
//    then rsp_err=4; rsp_balance unchanged.
//  4 No ack on the first issue, ack on the 2nd retry -> 3 pulses total, rsp_err=err value, retry count reset next cmd.
//  5 win&roundOver pulse while idle -> won=1; new cmd accepted -> won=0 that next cycle; reset mid-WAIT_ACK
//    -> all outputs at reset values, no rsp_valid.
//  6 Macro on, balance=40 captured, bid 41 -> rsp_valid 1 cycle after accept, rsp_err=5, no bid pulse;
//    bid 40 -> issued normally.

Source files
------------

// File: rtl/bidder_port_agent.sv
// Bidder-side endpoint of one BIDS22 bidder port: issues bid/retract, waits for ack with retry.
// Optional local funds pre-check enabled by defining BID_LOCAL_FUNDS_CHECK_EN.
module bidder_port_agent #(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned BAL_W       = 32,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_retract,
  input  logic [AMT_W-1:0] i_cmd_amt,
  output logic             o_bid,
  output logic             o_retract,
  output logic [AMT_W-1:0] o_bid_amt,
  input  logic             i_ack,
  input  logic [1:0]       i_err,
  input  logic             i_win,
  input  logic [BAL_W-1:0] i_balance,
  input  logic             i_round_over,
  output logic             o_rsp_valid,
  output logic [2:0]       o_rsp_err,
  output logic [BAL_W-1:0] o_rsp_balance,
  output logic             o_won,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StResp} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_is_retract;
  logic [AMT_W-1:0]   r_bid_amt;
  logic [7:0]         r_timer;
  logic [2:0]         r_retry;
  logic [2:0]         r_rsp_err;
  logic [BAL_W-1:0]   r_rsp_balance;
  logic               r_won;

  logic               w_accept;
  logic               w_local_fail;
  logic               w_funds_short;
  logic               w_ack_take;
  logic               w_timeout;
  logic               w_retry_inc;
  logic               w_timer_last;

`ifdef BID_LOCAL_FUNDS_CHECK_EN
  // Balance is unknown until the controller has acked once since reset.
  logic r_bal_seen;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bal_seen <= 1'b0;
    end else if (w_ack_take) begin
      r_bal_seen <= 1'b1;
    end
  end

  assign w_funds_short = ~i_cmd_retract & r_bal_seen & (BAL_W'(i_cmd_amt) > r_rsp_balance);
`else
  assign w_funds_short = 1'b0;
`endif

  assign w_timer_last = (r_timer == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_cmd_ready  = 1'b0;
    o_bid        = 1'b0;
    o_retract    = 1'b0;
    o_rsp_valid  = 1'b0;
    w_accept     = 1'b0;
    w_local_fail = 1'b0;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    w_retry_inc  = 1'b0;
    case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          if (w_funds_short) begin
            w_local_fail = 1'b1;
            w_state_nxt  = StResp;
          end else begin
            w_state_nxt = StIssue;
          end
        end
      end
      StIssue: begin
        o_bid       = ~r_is_retract;
        o_retract   = r_is_retract;
        w_state_nxt = StWaitAck;
      end
      StWaitAck: begin
        if (i_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = StResp;
        end else if (w_timer_last) begin
          if (r_retry < 3'(MAX_RETRY)) begin
            w_retry_inc = 1'b1;
            w_state_nxt = StIssue;
          end else begin
            w_timeout   = 1'b1;
            w_state_nxt = StResp;
          end
        end
      end
      StResp: begin
        o_rsp_valid = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_is_retract  <= 1'b0;
      r_bid_amt     <= '0;
      r_timer       <= '0;
      r_retry       <= '0;
      r_rsp_err     <= '0;
      r_rsp_balance <= '0;
      r_won         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_retract <= i_cmd_retract;
        r_retry      <= '0;
        // A locally rejected bid never reaches the controller, so the bus amount is left alone.
        if (!w_local_fail) begin
          r_bid_amt <= i_cmd_retract ? '0 : i_cmd_amt;
        end
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 3'd1;
      end

      if (r_state == StIssue) begin
        r_timer <= '0;
      end else if (r_state == StWaitAck && !i_ack) begin
        r_timer <= r_timer + 8'd1;
      end

      if (w_ack_take) begin
        r_rsp_err     <= {1'b0, i_err};
        r_rsp_balance <= i_balance;
      end else if (w_timeout) begin
        r_rsp_err <= 3'd4;
      end else if (w_local_fail) begin
        r_rsp_err <= 3'd5;
      end

      if (w_accept) begin
        r_won <= 1'b0;
      end else if (i_win && i_round_over) begin
        r_won <= 1'b1;
      end
    end
  end

  assign o_bid_amt     = r_bid_amt;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_balance = r_rsp_balance;
  assign o_won         = r_won;
  assign o_busy        = ~o_cmd_ready;

endmodule

// File: tb/tb_bidder_port_agent.sv
// Directed bench for bidder_port_agent: table of command transactions plus won/reset sequences.
module tb_bidder_port_agent;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_retract = 1'b0;
  logic [15:0] i_cmd_amt = '0;
  logic        o_bid;
  logic        o_retract;
  logic [15:0] o_bid_amt;
  logic        i_ack = 1'b0;
  logic [1:0]  i_err = '0;
  logic        i_win = 1'b0;
  logic [31:0] i_balance = '0;
  logic        i_round_over = 1'b0;
  logic        o_rsp_valid;
  logic [2:0]  o_rsp_err;
  logic [31:0] o_rsp_balance;
  logic        o_won;
  logic        o_busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bidder_port_agent #(
    .AMT_W      (16),
    .BAL_W      (32),
    .ACK_TIMEOUT(15),
    .MAX_RETRY  (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_retract(i_cmd_retract),
    .i_cmd_amt    (i_cmd_amt),
    .o_bid        (o_bid),
    .o_retract    (o_retract),
    .o_bid_amt    (o_bid_amt),
    .i_ack        (i_ack),
    .i_err        (i_err),
    .i_win        (i_win),
    .i_balance    (i_balance),
    .i_round_over (i_round_over),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_err    (o_rsp_err),
    .o_rsp_balance(o_rsp_balance),
    .o_won        (o_won),
    .o_busy       (o_busy)
  );

  // skip = issues left unacked before acking; ack lands ack_lat cycles after that pulse.
  typedef struct {
    logic        retract;
    logic [15:0] amt;
    int          skip;
    int          ack_lat;
    logic [1:0]  err;
    logic [31:0] bal;
    logic [2:0]  exp_err;
    logic [31:0] exp_bal;
    int          exp_pulses;
    int          exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(o_cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_pulses"}, 32'({o_bid, o_retract}), 32'd0);
    chk({tag, "_amt"}, 32'(o_bid_amt), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
    chk({tag, "_rsp_bal"}, o_rsp_balance, 32'd0);
    chk({tag, "_won"}, 32'(o_won), 32'd0);
  endtask

  // Cycle 0 = accept cycle; cycle c is sampled on the falling edge inside it.
  task automatic run_cmd(input string tag, input vec_t v);
    int   pulses, rsp_cyc, rsp_cnt, last_pulse, ack_at;
    logic type_ok, amt_ok, space_ok;
    logic [2:0]  got_err;
    logic [31:0] got_bal;
    logic [15:0] exp_amt;
    pulses = 0; rsp_cyc = -1; rsp_cnt = 0; last_pulse = 0; ack_at = -1;
    type_ok = 1'b1; amt_ok = 1'b1; space_ok = 1'b1; got_err = '0; got_bal = '0;
    exp_amt = v.retract ? 16'd0 : v.amt;
    @(negedge clk);
    chk({tag, "_ready_in"}, 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1; i_cmd_retract = v.retract; i_cmd_amt = v.amt;
    i_err = v.err; i_balance = v.bal;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      i_ack = (c == ack_at);
      @(negedge clk);
      if (o_bid || o_retract) begin
        pulses++;
        if (o_bid !== !v.retract || o_retract !== v.retract) type_ok = 1'b0;
        if (o_bid_amt !== exp_amt) amt_ok = 1'b0;
        if (pulses > 1 && c - last_pulse != 16) space_ok = 1'b0;
        last_pulse = c;
        if (pulses == v.skip + 1) ack_at = c + v.ack_lat;
      end
      if (o_rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; got_err = o_rsp_err; got_bal = o_rsp_balance;
        end
      end
      if (rsp_cyc >= 0 && c == rsp_cyc + 1) begin
        chk({tag, "_ready_after"}, 32'(o_cmd_ready), 32'd1);
        chk({tag, "_err_hold"}, 32'(o_rsp_err), 32'(v.exp_err));
        if (v.exp_pulses > 0) chk({tag, "_amt_hold"}, 32'(o_bid_amt), 32'(exp_amt));
        break;
      end
    end
    i_ack = 1'b0;
    chk({tag, "_pulses"}, 32'(pulses), 32'(v.exp_pulses));
    chk({tag, "_pulse_type"}, 32'(type_ok), 32'd1);
    chk({tag, "_pulse_amt"}, 32'(amt_ok), 32'd1);
    chk({tag, "_spacing"}, 32'(space_ok), 32'd1);
    chk({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_rsp));
    chk({tag, "_rsp_count"}, 32'(rsp_cnt), 32'd1);
    chk({tag, "_rsp_err"}, 32'(got_err), 32'(v.exp_err));
    chk({tag, "_rsp_bal"}, got_bal, v.exp_bal);
  endtask

  initial begin
    vec_t m;
    logic quiet;
    //           ret   amt      skip lat err   bal     eerr  ebal   pul rsp
    vecs[0] = '{1'b0, 16'd100,   0,  1, 2'd0, 32'd900, 3'd0, 32'd900, 1,  3};
    vecs[1] = '{1'b1, 16'd77,    0,  1, 2'd3, 32'd850, 3'd3, 32'd850, 1,  3};
    vecs[2] = '{1'b0, 16'd200,   2,  1, 2'd2, 32'd123, 3'd2, 32'd123, 3, 35};
    vecs[3] = '{1'b0, 16'd50,    9,  1, 2'd0, 32'd777, 3'd4, 32'd123, 4, 65};
    vecs[4] = '{1'b0, 16'd9,     3, 15, 2'd1, 32'd60,  3'd1, 32'd60,  4, 65};
    vecs[5] = '{1'b0, 16'd0,     0,  1, 2'd1, 32'd5,   3'd1, 32'd5,   1,  3};
    vecs[6] = '{1'b0, 16'd3,     1,  1, 2'd0, 32'd70,  3'd0, 32'd70,  2, 19};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_cmd($sformatf("v%0d", i), vecs[i]);
    end

    m = '{1'b0, 16'd10, 0, 1, 2'd0, 32'd40, 3'd0, 32'd40, 1, 3};
    run_cmd("fund_setup", m);
`ifdef BID_LOCAL_FUNDS_CHECK_EN
    m = '{1'b0, 16'd41, 0, 1, 2'd0, 32'd40, 3'd5, 32'd40, 0, 1};
`else
    m = '{1'b0, 16'd41, 0, 1, 2'd0, 32'd40, 3'd0, 32'd40, 1, 3};
`endif
    run_cmd("fund_over", m);
    m = '{1'b0, 16'd40, 0, 1, 2'd0, 32'd35, 3'd0, 32'd35, 1, 3};
    run_cmd("fund_equal", m);

    // won: win alone ignored, win&roundOver sets, clear beats set on accept
    @(negedge clk);
    i_win = 1'b1;
    @(negedge clk);
    i_win = 1'b0;
    chk("won_win_only", 32'(o_won), 32'd0);
    i_win = 1'b1; i_round_over = 1'b1;
    @(negedge clk);
    i_win = 1'b0; i_round_over = 1'b0;
    chk("won_set", 32'(o_won), 32'd1);
    @(negedge clk);
    chk("won_sticky", 32'(o_won), 32'd1);
    i_cmd_valid = 1'b1; i_cmd_retract = 1'b0; i_cmd_amt = 16'd5;
    i_win = 1'b1; i_round_over = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_win = 1'b0; i_round_over = 1'b0;
    chk("won_clear", 32'(o_won), 32'd0);
    chk("issue_bid", 32'(o_bid), 32'd1);
    // ack held through the ISSUE edge only must be ignored
    i_ack = 1'b1; i_err = 2'd0; i_balance = 32'd1;
    @(posedge clk); #1;
    i_ack = 1'b0;
    @(negedge clk);
    chk("issue_ack_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("issue_ack_ignored", 32'(o_rsp_valid), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_vals("midreset");
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_rsp_valid || o_bid || o_retract) quiet = 1'b0;
    end
    chk("midreset_quiet", 32'(quiet), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
